// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for a main/side intersection. It drives an external countdown
// timer and decodes the lamp and walk outputs from its state register.
module traffic_phase_ctrl #(
  parameter int unsigned WIDTH = 32'd4,
  parameter int unsigned T_MG  = 32'd9,
  parameter int unsigned T_Y   = 32'd2,
  parameter int unsigned T_AR  = 32'd1,
  parameter int unsigned T_SG  = 32'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             side_req,
  input  logic             ped_req,
  input  logic             timer_done,
  output logic             timer_load,
  output logic             timer_enable,
  output logic [WIDTH-1:0] timer_load_value,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk
);

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_A   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } state_t;

  localparam logic [WIDTH-1:0] LV_MG = WIDTH'(T_MG);
  localparam logic [WIDTH-1:0] LV_Y  = WIDTH'(T_Y);
  localparam logic [WIDTH-1:0] LV_AR = WIDTH'(T_AR);
  localparam logic [WIDTH-1:0] LV_SG = WIDTH'(T_SG);

  // Kept as a plain vector so the unused code 3'b111 is representable.
  logic [2:0] state_r;
  state_t     next_state;
  logic       req_pending_r;
  logic       ped_pending_r;
  logic       walk_active_r;
  logic       enter_sg;

  // Next-state and timer control.
  always_comb begin
    next_state       = state_t'(state_r);
    timer_load       = 1'b0;
    timer_load_value = '0;
    timer_enable     = 1'b1;
    enter_sg         = 1'b0;
    case (state_r)
      INIT: begin
        next_state       = MAIN_GREEN;
        timer_load       = 1'b1;
        timer_load_value = LV_MG;
        timer_enable     = 1'b0;
      end
      MAIN_GREEN: begin
        // With no request the timer parks at zero and green is held.
        if (timer_done && req_pending_r) begin
          next_state       = MAIN_YELLOW;
          timer_load       = 1'b1;
          timer_load_value = LV_Y;
        end else begin
          next_state = MAIN_GREEN;
        end
      end
      MAIN_YELLOW: begin
        if (timer_done) begin
          next_state       = ALL_RED_A;
          timer_load       = 1'b1;
          timer_load_value = LV_AR;
        end else begin
          next_state = MAIN_YELLOW;
        end
      end
      ALL_RED_A: begin
        if (timer_done) begin
          next_state       = SIDE_GREEN;
          timer_load       = 1'b1;
          timer_load_value = LV_SG;
          enter_sg         = 1'b1;
        end else begin
          next_state = ALL_RED_A;
        end
      end
      SIDE_GREEN: begin
        if (timer_done) begin
          next_state       = SIDE_YELLOW;
          timer_load       = 1'b1;
          timer_load_value = LV_Y;
        end else begin
          next_state = SIDE_GREEN;
        end
      end
      SIDE_YELLOW: begin
        if (timer_done) begin
          next_state       = ALL_RED_B;
          timer_load       = 1'b1;
          timer_load_value = LV_AR;
        end else begin
          next_state = SIDE_YELLOW;
        end
      end
      ALL_RED_B: begin
        if (timer_done) begin
          next_state       = MAIN_GREEN;
          timer_load       = 1'b1;
          timer_load_value = LV_MG;
        end else begin
          next_state = ALL_RED_B;
        end
      end
      default: begin
        next_state   = INIT;
        timer_enable = 1'b0;
      end
    endcase
  end

  // Lamp and walk decode, driven only from registers.
  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    case (state_r)
      MAIN_GREEN:  main_light = 3'b001;
      MAIN_YELLOW: main_light = 3'b010;
      SIDE_GREEN:  side_light = 3'b001;
      SIDE_YELLOW: side_light = 3'b010;
      default: begin
        main_light = 3'b100;
        side_light = 3'b100;
      end
    endcase
    walk = (state_r == SIDE_GREEN) && walk_active_r;
  end

  // State and request latches; a new request wins over the service clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= INIT;
      req_pending_r <= 1'b0;
      ped_pending_r <= 1'b0;
      walk_active_r <= 1'b0;
    end else begin
      state_r <= next_state;
      if (side_req || ped_req) begin
        req_pending_r <= 1'b1;
      end else if (enter_sg) begin
        req_pending_r <= 1'b0;
      end else begin
        req_pending_r <= req_pending_r;
      end
      if (enter_sg) begin
        walk_active_r <= ped_pending_r | ped_req;
        ped_pending_r <= 1'b0;
      end else begin
        walk_active_r <= walk_active_r;
        ped_pending_r <= ped_pending_r | ped_req;
      end
    end
  end

endmodule
